// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: NOP encoding,
// default address width and the queue entry layout.
package fetch_queue_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned XLEN_MAX     = 64;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // pc is sized for the widest supported XLEN; narrower builds keep the
  // upper bits at zero
  typedef struct packed {
    logic [31:0]         instr;
    logic [XLEN_MAX-1:0] pc;
  } fqEntry_t;

  localparam int unsigned ENTRY_W = $bits(fqEntry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer storage for the fetch queue: push/pop/clear with occupancy
// count. Pop on empty is ignored; push on full succeeds only with a pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [WIDTH-1:0]        pushData,
  output logic [WIDTH-1:0]        headData,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign doPop    = pop && (count != '0) && !clear;
  assign doPush   = push && ((count != FULL) || doPop) && !clear;
  assign headData = mem[rdPtr];

  // pointer and occupancy bookkeeping; clear wins over push/pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  // entry storage, no reset needed (head is masked while empty)
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word fetches, tracks in-flight
// requests, drops responses made stale by a redirect and buffers the rest
// for decode. Optional performance counters under `FETCH_PERF_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            validD,
  input  logic            readyD,
  output logic [31:0]     instrD,
  output logic [XLEN-1:0] pcD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     drop_cnt_total
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]    DEPTH_LIM = (CNT_W + 1)'(DEPTH);
  localparam logic [XLEN-1:0]   PC_STEP   = XLEN'(4);

  logic [XLEN-1:0]  fetchPc;
  logic [XLEN-1:0]  respPc;
  logic [XLEN-1:0]  redirectTarget;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstandingNext;
  logic [CNT_W-1:0] dropCnt;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   inFlight;
  logic             grant;
  logic             respTake;
  logic             respDrop;
  logic             respPush;
  logic             popHead;
  fqEntry_t         pushEntry;
  fqEntry_t         headEntry;
  logic             unusedPcHi;

  assign redirectTarget  = redirect_pc & ~XLEN'(3);
  // queued plus in-flight must fit, so every response has a slot reserved
  assign inFlight        = {1'b0, count} + {1'b0, outstanding};
  assign imem_req        = reset && !redirect && (inFlight < DEPTH_LIM);
  assign imem_addr       = fetchPc;
  assign grant           = imem_req && imem_gnt;
  assign respTake        = imem_rvalid && (outstanding != '0);
  assign respDrop        = respTake && (dropCnt != '0);
  assign respPush        = respTake && (dropCnt == '0) && !redirect;
  assign validD          = (count != '0) && !redirect;
  assign popHead         = validD && readyD;
  assign outstandingNext = outstanding + CNT_W'(grant) - CNT_W'(respTake);
  // pc bits above XLEN are always zero; fold them so they count as consumed
  assign unusedPcHi      = ^headEntry.pc;

  // build the queue entry for an accepted response
  always_comb begin
    pushEntry                = '0;
    pushEntry.instr          = imem_rdata;
    pushEntry.pc[XLEN-1:0]   = respPc;
  end

  // fetch/response PCs, in-flight and pending-drop tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCnt     <= '0;
    end else begin
      outstanding <= outstandingNext;
      if (redirect) begin
        // everything still in flight after this cycle belongs to the old stream
        fetchPc <= redirectTarget;
        respPc  <= redirectTarget;
        dropCnt <= outstandingNext;
      end else begin
        if (grant)    fetchPc <= fetchPc + PC_STEP;
        if (respPush) respPc  <= respPc + PC_STEP;
        if (respDrop) dropCnt <= dropCnt - CNT_W'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (respPush),
    .pop      (popHead),
    .clear    (redirect),
    .pushData (pushEntry),
    .headData (headEntry),
    .count    (count)
  );

  // decode-facing head, NOP/zero when nothing valid
  always_comb begin
    instrD = NOP_INSTR;
    pcD    = '0;
    if (validD) begin
      instrD = headEntry.instr;
      pcD    = headEntry.pc[XLEN-1:0];
    end
  end

`ifdef FETCH_PERF_EN
  // pushed and discarded response counters, free-running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt      <= '0;
      drop_cnt_total <= '0;
    end else begin
      if (respPush) fetch_cnt      <= fetch_cnt + 32'd1;
      if (respDrop) drop_cnt_total <= drop_cnt_total + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter XLEN, default 32: PC and address width, 32 or 64.
REQ-002 Parameter DEPTH, default 4: instruction queue entries, power of two, 2..16.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset, word-aligned.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 imem_req  out  1  fetch request valid.
REQ-007 imem_addr  out  XLEN  fetch address, bits [1:0] always 0.
REQ-008 imem_gnt  in  1  request accepted this cycle (handshake imem_req & imem_gnt).
REQ-009 imem_rvalid  in  1  one response this cycle, in request order, any latency >=1.
REQ-010 imem_rdata  in  32  response instruction word.
REQ-011 redirect  in  1  control change from execute; flush and refetch.
REQ-012 redirect_pc  in  XLEN  new fetch target.
REQ-013 validD  out  1  queue head holds an instruction.
REQ-014 readyD  in  1  decode accepts head (driven as !stallD).
REQ-015 instrD, pcD  out  32, XLEN  head instruction and its PC.

Function
REQ-016 Request issue SHALL occur when count + outstanding < DEPTH and redirect is low; otherwise imem_req SHALL be 0.
REQ-017 On imem_req & imem_gnt: fetch PC += 4 (modulo 2^XLEN, wrap silent), outstanding += 1.
REQ-018 imem_addr SHALL stay stable while imem_req & !imem_gnt, except a redirect may withdraw it.
REQ-019 Response handling: if drop_cnt > 0, discard word, decrement drop_cnt and outstanding; else push {imem_rdata, resp_pc}, resp_pc += 4, decrement outstanding.
REQ-020 imem_rvalid with outstanding == 0 SHALL be ignored, no state change.
REQ-021 Pop on validD & readyD; push and pop in the same cycle SHALL both occur, count unchanged.
REQ-022 No overflow SHALL be possible: REQ-016 reserves a slot for every outstanding request, including those pending drop.
REQ-023 Latency: response in cycle N visible on validD/instrD in cycle N+1 (registered queue, no bypass).
REQ-024 Redirect cycle: queue emptied, pushes and pops that cycle cancelled, fetch PC and resp_pc loaded with {redirect_pc[XLEN-1:2],2'b00}, drop_cnt <= outstanding after this cycle's gnt/rvalid accounting; issue resumes next cycle.
REQ-025 Redirect while drop_cnt > 0 SHALL accumulate: drop_cnt covers all outstanding requests.
REQ-026 validD SHALL be 0 in the redirect cycle and until a post-redirect response is pushed.
REQ-027 When validD = 0, instrD SHALL read 32'h00000013 (NOP) and pcD 0.

Reset
REQ-028 While reset = 0: imem_req 0, imem_addr RESET_PC, validD 0, instrD NOP, pcD 0, count/outstanding/drop_cnt 0, fetch PC and resp_pc RESET_PC.
REQ-029 Reset mid-operation SHALL discard all queued and in-flight work; late responses fall under REQ-020.
REQ-030 First request SHALL be asserted in the first cycle after reset deasserts.

Configuration
REQ-031 Macro FETCH_PERF_EN defined: outputs fetch_cnt and drop_cnt_total (32 bits each, reset 0, wrapping) count pushed and discarded responses respectively.
REQ-032 Macro FETCH_PERF_EN undefined: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Shared package SHALL hold the NOP constant, XLEN default and fetch-queue entry struct {instr, pc}.
REQ-034 Storage SHALL be a sub-module fetch_fifo (DEPTH, entry width, push/pop/clear, count) instantiated once.

Verification
REQ-035 Zero-wait memory (gnt=1, rvalid 1 cycle later), readyD=1 -> after reset pcD 0,4,8,C on consecutive cycles from cycle 3.
REQ-036 readyD=0, DEPTH=4 -> exactly 4 requests issued, imem_req then 0, validD=1, pcD stays 0.
REQ-037 3 requests outstanding, redirect_pc=0x103 -> next request addr 0x100, 3 stale responses dropped, first validD shows pcD 0x100.
REQ-038 Two redirects 2 cycles apart (0x200, then 0x300) with 4-cycle memory latency -> no instruction from 0x200 or pre-redirect stream reaches validD; first pcD 0x300.
REQ-039 XLEN=32, redirect_pc=0xFFFFFFFC -> pcD 0xFFFFFFFC then 0x00000000.
REQ-040 Reset asserted with 2 outstanding, responses arrive after release -> discarded; first pcD equals RESET_PC; with FETCH_PERF_EN, fetch_cnt 0 after reset.
